// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART command-frame sequencer: FSM states,
// error codes and default header bytes.
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_H1   = 3'd1,
        ST_CMD  = 3'd2,
        ST_LEN  = 3'd3,
        ST_PAY  = 3'd4,
        ST_CSUM = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_CSUM = 2'b10,
        ERR_TMO  = 2'b11
    } err_e;

    localparam logic [7:0] HDR0_DEF = 8'h55;
    localparam logic [7:0] HDR1_DEF = 8'hAA;

endpackage

// File: rtl/uart_rx_frame_ctrl_timeout.sv
// Inter-byte idle watchdog: counts cycles while a frame is open and pulses
// expired when TIMEOUT_CYC cycles pass without an accepted byte.
module uart_frame_timeout #(
    parameter int TIMEOUT_CYC = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_limit;

    assign at_limit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // A byte arriving in the limit cycle wins over the timeout.
    assign expired = run && !clr && at_limit;

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (!run || clr || at_limit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Turns the receiver byte stream into HDR0 HDR1 CMD LEN PAYLOAD CSUM frames,
// streams payload to a buffer and reports each frame as valid or errored.
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int         CLK_FREQ    = 50_000_000,
    parameter int         TIMEOUT_CYC = CLK_FREQ / 1000,
    parameter int         MAX_LEN     = 32,
    parameter int         ADDR_W      = 5,
    parameter logic [7:0] HDR0        = HDR0_DEF,
    parameter logic [7:0] HDR1        = HDR1_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [7:0]        frame_cmd,
    output logic [7:0]        frame_len,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              rx_done_dly_q, rx_done_dly_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_err_q, frame_err_d;
    err_e              err_code_q, err_code_d;
    logic [7:0]        frame_cmd_q, frame_cmd_d;
    logic [7:0]        frame_len_q, frame_len_d;
    logic              busy_q, busy_d;

    logic accept;
    logic expired;
    logic len_too_big;
    logic last_pay;
    logic csum_ok;

    // Rising edge of the strobe only, so a long rx_done pulse is one byte.
    assign accept      = rx_done && !rx_done_dly_q;
    assign len_too_big = (rx_data > 8'(MAX_LEN));
    assign last_pay    = (8'(idx_q) == (len_q - 8'd1));
    assign csum_ok     = (rx_data == csum_q);

    uart_frame_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run     (state_q != ST_IDLE),
        .clr     (accept),
        .expired (expired)
    );

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q       <= ST_IDLE;
            rx_done_dly_q <= 1'b0;
            cmd_q         <= '0;
            len_q         <= '0;
            csum_q        <= '0;
            idx_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            frame_cmd_q   <= '0;
            frame_len_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_done_dly_q <= rx_done_dly_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            csum_q        <= csum_d;
            idx_q         <= idx_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_len_q   <= frame_len_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rx_done_dly_d = rx_done;
        cmd_d         = cmd_q;
        len_d         = len_q;
        csum_d        = csum_q;
        idx_d         = idx_q;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == HDR0) state_d = ST_H1;
                end
                ST_H1: begin
                    if (rx_data == HDR1)      state_d = ST_CMD;
                    else if (rx_data == HDR0) state_d = ST_H1;
                    else                      state_d = ST_IDLE;
                end
                ST_CMD: begin
                    cmd_d   = rx_data;
                    csum_d  = rx_data;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    len_d  = rx_data;
                    csum_d = csum_q + rx_data;
                    if (rx_data == 8'd0) begin
                        state_d = ST_CSUM;
                    end else if (len_too_big) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PAY;
                        idx_d   = '0;
                    end
                end
                ST_PAY: begin
                    csum_d = csum_q + rx_data;
                    if (last_pay) begin
                        state_d = ST_CSUM;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
                ST_CSUM: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else if (expired) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_cmd_d   = frame_cmd_q;
        frame_len_d   = frame_len_q;
        busy_d        = (state_d != ST_IDLE);
        if (accept) begin
            unique case (state_q)
                ST_LEN: begin
                    if (len_too_big) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end
                end
                ST_PAY: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = rx_data;
                end
                ST_CSUM: begin
                    if (csum_ok) begin
                        frame_valid_d = 1'b1;
                        frame_cmd_d   = cmd_q;
                        frame_len_d   = len_q;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
                default: ;
            endcase
        end else if (expired) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign frame_cmd   = frame_cmd_q;
    assign frame_len   = frame_len_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: table-driven frames, hand-written
// timeout/reset/back-to-back sequences and random frames against a frame-level model.
module tb_uart_rx_frame_ctrl;

    localparam int TMO     = 300;
    localparam int MAX_LEN = 32;
    localparam int ADDR_W  = 5;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              rx_done = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_valid;
    logic              frame_err;
    logic [1:0]        err_code;
    logic [7:0]        frame_cmd;
    logic [7:0]        frame_len;
    logic              busy;

    always #5 sys_clk = ~sys_clk;

    uart_rx_frame_ctrl #(
        .CLK_FREQ    (50_000_000),
        .TIMEOUT_CYC (TMO),
        .MAX_LEN     (MAX_LEN),
        .ADDR_W      (ADDR_W),
        .HDR0        (8'h55),
        .HDR1        (8'hAA)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .frame_cmd   (frame_cmd),
        .frame_len   (frame_len),
        .busy        (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Event monitor: writes as (addr<<8)|data, valid frames as (cmd<<8)|len, errors as code.
    int wr_q[$];
    int val_q[$];
    int err_q[$];
    int coincide_cnt = 0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            if (wr_en)       wr_q.push_back((int'(wr_addr) << 8) | int'(wr_data));
            if (frame_valid) val_q.push_back((int'(frame_cmd) << 8) | int'(frame_len));
            if (frame_err)   err_q.push_back(int'(err_code));
            if (frame_valid && frame_err) coincide_cnt++;
        end
    end

    task automatic clear_mon();
        wr_q.delete();
        val_q.delete();
        err_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(negedge sys_clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge sys_clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap - 1) @(negedge sys_clk);
    endtask

    typedef struct {
        logic [0:11][7:0] bytes;
        int n;
        int hold;
        int pay_off;
        int exp_wr;
        int exp_valid;
        int exp_err;
        int exp_code;
        int exp_cmd;
        int exp_len;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    function automatic logic [0:11][7:0] pad(input logic [95:0] v, input int n);
        return v << (8 * (12 - n));
    endfunction

    task automatic send_vec(input int i, input int hold, input int gap);
        for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].bytes[j], hold, gap);
    endtask

    task automatic run_table();
        for (int i = 0; i < NV; i++) begin
            clear_mon();
            send_vec(i, vecs[i].hold, 3);
            idle(6);
            check($sformatf("v%0d_wr_cnt", i), wr_q.size(), vecs[i].exp_wr);
            for (int k = 0; k < wr_q.size() && k < vecs[i].exp_wr; k++)
                check($sformatf("v%0d_wr%0d", i, k), wr_q[k],
                      (k << 8) | int'(vecs[i].bytes[vecs[i].pay_off + k]));
            check($sformatf("v%0d_valid_cnt", i), val_q.size(), vecs[i].exp_valid);
            check($sformatf("v%0d_err_cnt", i), err_q.size(), vecs[i].exp_err);
            if (vecs[i].exp_valid != 0) begin
                check($sformatf("v%0d_cmd", i), int'(frame_cmd), vecs[i].exp_cmd);
                check($sformatf("v%0d_len", i), int'(frame_len), vecs[i].exp_len);
            end
            if (vecs[i].exp_err != 0)
                check($sformatf("v%0d_code", i), int'(err_code), vecs[i].exp_code);
            check($sformatf("v%0d_busy_end", i), int'(busy), 0);
        end
    endtask

    task automatic run_timeout();
        int k;
        int busy_at_t;
        clear_mon();
        send_byte(8'h55, 1, 3);
        send_byte(8'hAA, 1, 3);
        send_byte(8'h05, 1, 3);
        send_byte(8'h02, 1, 3);
        @(negedge sys_clk);
        rx_data = 8'h07;
        rx_done = 1'b1;
        k = 0;
        busy_at_t = 0;
        do begin
            @(negedge sys_clk);
            rx_done = 1'b0;
            k++;
            if (k == TMO) busy_at_t = int'(busy);
        end while (!frame_err && k < TMO + 50);
        check("tmo_latency", k, TMO + 1);
        check("tmo_code", int'(err_code), 3);
        check("tmo_busy_before", busy_at_t, 1);
        check("tmo_busy_after", int'(busy), 0);
        idle(4);
        check("tmo_err_cnt", err_q.size(), 1);
        check("tmo_wr_cnt", wr_q.size(), 1);
        check("tmo_valid_cnt", val_q.size(), 0);
        clear_mon();
        send_vec(0, 1, 3);
        idle(6);
        check("post_tmo_valid", val_q.size(), 1);
        check("post_tmo_err", err_q.size(), 0);
    endtask

    task automatic run_tie();
        clear_mon();
        send_byte(8'h55, 1, 3);
        send_byte(8'hAA, 1, 3);
        send_byte(8'h05, 1, 3);
        send_byte(8'h01, 1, 3);
        @(negedge sys_clk);
        rx_data = 8'h07;
        rx_done = 1'b1;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge sys_clk);
            rx_done = 1'b0;
        end
        rx_data = 8'h0D;
        rx_done = 1'b1;
        @(negedge sys_clk);
        rx_done = 1'b0;
        idle(6);
        check("tie_valid", val_q.size(), 1);
        check("tie_err", err_q.size(), 0);
        check("tie_frame", (int'(frame_cmd) << 8) | int'(frame_len), 16'h0501);
    endtask

    task automatic run_b2b();
        clear_mon();
        send_vec(0, 1, 1);
        send_vec(5, 1, 1);
        idle(6);
        check("b2b_valid_cnt", val_q.size(), 2);
        check("b2b_wr_cnt", wr_q.size(), 5);
        if (val_q.size() == 2) begin
            check("b2b_first", val_q[0], 16'h1003);
            check("b2b_second", val_q[1], 16'hFF02);
        end
    endtask

    task automatic run_reset();
        logic any_out;
        clear_mon();
        send_byte(8'h55, 1, 3);
        send_byte(8'hAA, 1, 3);
        send_byte(8'h10, 1, 3);
        send_byte(8'h03, 1, 3);
        @(negedge sys_clk);
        rx_data = 8'h01;
        rx_done = 1'b1;
        @(posedge sys_clk);
        #2;
        check("rst_pre_wr_en", int'(wr_en), 1);
        check("rst_pre_busy", int'(busy), 1);
        sys_rst = 1'b0;
        #1;
        any_out = |{wr_en, wr_addr, wr_data, frame_valid, frame_err,
                    err_code, frame_cmd, frame_len, busy};
        check("rst_outputs_zero", int'(any_out), 0);
        rx_done = 1'b0;
        idle(2);
        sys_rst = 1'b1;
        clear_mon();
        send_vec(0, 1, 3);
        idle(6);
        check("post_rst_valid", val_q.size(), 1);
        check("post_rst_err", err_q.size(), 0);
        check("post_rst_wr_cnt", wr_q.size(), 3);
    endtask

    // Frame-level reference: expected writes and outcome follow from the frame rules directly.
    task automatic run_random(input int n_frames);
        for (int f = 0; f < n_frames; f++) begin
            logic [7:0] pay[$];
            int exp_wr[$];
            int hold, sel, len, sum, junk_n, exp_valid, exp_code;
            logic [7:0] cmd, csum_byte, b;
            clear_mon();
            hold = int'($urandom_range(1, 3));
            sel = int'($urandom_range(0, 99));
            if (sel < 25)      len = MAX_LEN;
            else if (sel < 35) len = int'($urandom_range(MAX_LEN + 1, 255));
            else if (sel < 42) len = 0;
            else               len = int'($urandom_range(1, MAX_LEN - 1));
            cmd = 8'($urandom);
            sum = int'(cmd) + len;
            for (int i = 0; i < len && len <= MAX_LEN; i++) begin
                b = 8'($urandom);
                pay.push_back(b);
                exp_wr.push_back((i << 8) | int'(b));
                sum += int'(b);
            end
            csum_byte = 8'(sum % 256);
            exp_valid = 0;
            exp_code = 0;
            if (len > MAX_LEN) begin
                exp_code = 1;
            end else if ($urandom_range(0, 3) == 0) begin
                csum_byte = 8'((sum + int'($urandom_range(1, 255))) % 256);
                exp_code = 2;
            end else begin
                exp_valid = 1;
            end
            junk_n = int'($urandom_range(0, 2));
            for (int j = 0; j < junk_n; j++) begin
                b = 8'($urandom);
                if (b == 8'h55) b = 8'h56;
                send_byte(b, hold, int'($urandom_range(1, 4)));
            end
            send_byte(8'h55, hold, int'($urandom_range(1, 4)));
            send_byte(8'hAA, hold, int'($urandom_range(1, 4)));
            send_byte(cmd, hold, int'($urandom_range(1, 4)));
            send_byte(8'(len), hold, int'($urandom_range(1, 4)));
            if (len <= MAX_LEN) begin
                foreach (pay[i]) send_byte(pay[i], hold, int'($urandom_range(1, 4)));
                send_byte(csum_byte, hold, int'($urandom_range(1, 4)));
            end
            idle(6);
            check($sformatf("r%0d_wr_cnt", f), wr_q.size(), exp_wr.size());
            for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++)
                check($sformatf("r%0d_wr%0d", f, k), wr_q[k], exp_wr[k]);
            check($sformatf("r%0d_valid_cnt", f), val_q.size(), exp_valid);
            check($sformatf("r%0d_err_cnt", f), err_q.size(), (exp_valid != 0) ? 0 : 1);
            if (exp_valid != 0)
                check($sformatf("r%0d_frame", f), (int'(frame_cmd) << 8) | int'(frame_len),
                      (int'(cmd) << 8) | len);
            else
                check($sformatf("r%0d_code", f), int'(err_code), exp_code);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0] = '{pad({8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19}, 8),
                    8, 1, 4, 3, 1, 0, 0, 8'h10, 8'h03};
        vecs[1] = '{pad({8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18}, 8),
                    8, 1, 4, 3, 0, 1, 2, 0, 0};
        vecs[2] = '{pad({8'h55, 8'hAA, 8'h01, 8'h21}, 4),
                    4, 1, 4, 0, 0, 1, 1, 0, 0};
        vecs[3] = '{pad({8'h55, 8'h55, 8'hAA, 8'h22, 8'h00, 8'h22}, 6),
                    6, 217, 5, 0, 1, 0, 0, 8'h22, 8'h00};
        vecs[4] = '{pad({8'h55, 8'h12, 8'h55, 8'hAA, 8'h01, 8'h01, 8'h07, 8'h09}, 8),
                    8, 1, 6, 1, 1, 0, 0, 8'h01, 8'h01};
        vecs[5] = '{pad({8'h55, 8'hAA, 8'hFF, 8'h02, 8'h80, 8'h90, 8'h11}, 7),
                    7, 1, 4, 2, 1, 0, 0, 8'hFF, 8'h02};
        vecs[6] = '{pad({8'h55, 8'hAA, 8'h07, 8'h00, 8'h08}, 5),
                    5, 2, 4, 0, 0, 1, 2, 0, 0};

        idle(3);
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pulses", int'({frame_valid, frame_err}), 0);
        check("reset_err_code", int'(err_code), 0);
        check("reset_frame", (int'(frame_cmd) << 8) | int'(frame_len), 0);
        sys_rst = 1'b1;
        idle(2);

        run_table();
        run_timeout();
        run_tie();
        run_b2b();
        run_reset();
        run_random(40);

        check("valid_err_coincide", coincide_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
